snd_cmd_queue: RTL and testbench

// Sound-CPU command/interrupt front end for the System 1 sound subsystem.
// It sits between the main-CPU sound-command strobe and the Z80 sound CPU.
// It queues main-CPU commands in a FIFO of parametrised depth, so back-to-back commands are no longer lost.

---
 rtl/snd_cmd_if.sv | 25 ++
 rtl/snd_cmd_queue.sv | 99 +++++++++
 tb/tb_snd_cmd_queue.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snd_cmd_if.sv
// Main-CPU / sound-CPU side signals of the sound command queue, grouped for port binding.
// Handshake semantics: sndstart is a level strobe whose rising edge offers sndno; cmd_rd is high for the
// whole sound-CPU read and its falling edge consumes the head; cpu_nmia/cpu_irqa are one-cycle acks.
interface snd_cmd_if;
  logic [7:0] sndno;
  logic       sndstart;
  logic       cmd_rd;
  logic       cpu_irqa;
  logic       cpu_nmia;
  logic       ovf_clr;
  logic       cpu_irq;
  logic       cpu_nmi;
  logic [7:0] comlatch;
  logic [7:0] status;

  modport master (
    output sndno, sndstart, cmd_rd, cpu_irqa, cpu_nmia, ovf_clr,
    input  cpu_irq, cpu_nmi, comlatch, status
  );

  modport slave (
    input  sndno, sndstart, cmd_rd, cpu_irqa, cpu_nmia, ovf_clr,
    output cpu_irq, cpu_nmi, comlatch, status
  );
endinterface

// File: rtl/snd_cmd_queue.sv
// Sound-CPU command FIFO with one NMI per queued entry, plus a free-running timer IRQ.
// All state advances only on clk8M_en cycles; reset is asynchronous and active-high.
module snd_cmd_queue #(
  parameter int DEPTH_LOG2    = 2,
  parameter int TICKS_PER_IRQ = 33333,
  parameter int CNT_W         = 17
) (
  input  logic      clk40M,
  input  logic      reset,
  input  logic      clk8M_en,
  snd_cmd_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_psndstart, r_prd;
  logic             r_ovf, r_head_sig, r_nmi, r_irq;
  logic [7:0]       r_comlatch;
  logic [CNT_W-1:0] r_timer;

  logic             w_empty, w_full;
  logic             w_push_req, w_pop, w_push, w_ovf_set, w_bypass, w_timer_tc;
  logic [PW-1:0]    w_rd_ptr_next;
  logic [CW-1:0]    w_count_next;
  logic [31:0]      w_count_wide;
  logic [3:0]       w_status_cnt;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_push_req    = bus.sndstart && !r_psndstart;
  assign w_pop         = !bus.cmd_rd && r_prd && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_ovf_set     = w_push_req && !w_push;
  assign w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
  assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
  // When the byte being written becomes the head, forward it instead of reading the not-yet-written slot.
  assign w_bypass      = w_push && (w_count_next == CW'(1));
  assign w_timer_tc    = (r_timer == CNT_W'(TICKS_PER_IRQ - 1));

  assign w_count_wide  = 32'(r_count);
  assign w_status_cnt  = (w_count_wide > 32'd15) ? 4'hF : w_count_wide[3:0];

  always_ff @(posedge clk40M) begin
    if (clk8M_en && w_push) r_mem[r_wr_ptr] <= bus.sndno;
  end

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_psndstart <= 1'b0;
      r_prd       <= 1'b0;
      r_ovf       <= 1'b0;
      r_head_sig  <= 1'b0;
      r_nmi       <= 1'b0;
      r_irq       <= 1'b0;
      r_comlatch  <= 8'h00;
      r_timer     <= '0;
    end else if (clk8M_en) begin
      r_psndstart <= bus.sndstart;
      r_prd       <= bus.cmd_rd;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_count_next != '0) r_comlatch <= w_bypass ? bus.sndno : r_mem[w_rd_ptr_next];

      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;

      // head_sig marks that the current head has had its NMI; it re-arms only when the head is popped.
      if (bus.cpu_nmia) begin
        r_nmi <= 1'b0;
      end else if (!w_empty && !r_head_sig && !r_nmi) begin
        r_nmi      <= 1'b1;
        r_head_sig <= 1'b1;
      end
      if (w_pop) r_head_sig <= 1'b0;

      if (w_timer_tc) begin
        r_timer <= '0;
        r_irq   <= 1'b1;
      end else begin
        r_timer <= r_timer + CNT_W'(1);
        if (bus.cpu_irqa) r_irq <= 1'b0;
      end
    end
  end

  assign bus.cpu_irq  = r_irq;
  assign bus.cpu_nmi  = r_nmi;
  assign bus.comlatch = r_comlatch;
  assign bus.status   = {r_ovf, w_empty, w_full, 1'b0, w_status_cnt};
endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed and randomized bench for snd_cmd_queue, checked every enabled cycle against a
// queue-based reference model of the command FIFO, NMI-per-entry and timer IRQ behaviour.
module tb_snd_cmd_queue;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TICKS      = 10;

  logic clk40M;
  logic reset;
  logic clk8M_en;
  int   checks   = 0;
  int   failures = 0;
  int   n_tick   = 0;

  snd_cmd_if bus ();

  snd_cmd_queue #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .TICKS_PER_IRQ(TICKS),
    .CNT_W        (4)
  ) dut (
    .clk40M  (clk40M),
    .reset   (reset),
    .clk8M_en(clk8M_en),
    .bus     (bus)
  );

  // Clock and a randomly spaced clock enable that changes only on the falling edge.
  initial begin
    clk40M = 1'b0;
    forever #10 clk40M = ~clk40M;
  end

  initial begin
    clk8M_en = 1'b0;
    forever begin
      @(negedge clk40M);
      clk8M_en = ($urandom_range(0, 3) == 0);
    end
  end

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_latch;
  bit         m_ovf, m_nmi, m_announced, m_irq, m_ps, m_pr;
  int         m_tmr;

  task automatic model_reset();
    mq.delete();
    m_latch     = 8'h00;
    m_ovf       = 1'b0;
    m_nmi       = 1'b0;
    m_announced = 1'b0;
    m_irq       = 1'b0;
    m_ps        = 1'b0;
    m_pr        = 1'b0;
    m_tmr       = 0;
  endtask

  task automatic model_step();
    bit had_entries, push_req, pop, dropped;
    had_entries = (mq.size() > 0);
    push_req    = bus.sndstart && !m_ps;
    pop         = !bus.cmd_rd && m_pr && had_entries;
    dropped     = 1'b0;
    if (bus.cpu_nmia) m_nmi = 1'b0;
    else if (had_entries && !m_announced && !m_nmi) begin
      m_nmi       = 1'b1;
      m_announced = 1'b1;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_announced = 1'b0;
    end
    if (push_req) begin
      if (mq.size() < DEPTH) mq.push_back(bus.sndno);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    if (mq.size() > 0) m_latch = mq[0];
    if (m_tmr == TICKS - 1) begin
      m_tmr = 0;
      m_irq = 1'b1;
    end else begin
      m_tmr++;
      if (bus.cpu_irqa) m_irq = 1'b0;
    end
    m_ps = bus.sndstart;
    m_pr = bus.cmd_rd;
  endtask

  function automatic logic [7:0] model_status();
    int n;
    n = mq.size();
    return {m_ovf, (n == 0), (n == DEPTH), 1'b0, 4'(n)};
  endfunction

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("comlatch", 32'(bus.comlatch), 32'(m_latch));
    chk("cpu_nmi",  32'(bus.cpu_nmi),  32'(m_nmi));
    chk("cpu_irq",  32'(bus.cpu_irq),  32'(m_irq));
    chk("status",   32'(bus.status),   32'(model_status()));
  endtask

  // Advance to the next enabled edge, step the model, sample 1 ns later.
  task automatic tick();
    int guard;
    guard = 0;
    do begin
      @(posedge clk40M);
      guard++;
    end while (!clk8M_en && guard < 64);
    if (guard >= 64) begin
      failures++;
      $error("FAIL en_timeout observed=%0d expected=<64", guard);
    end
    model_step();
    n_tick++;
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.sndno    = b;
    bus.sndstart = 1'b1;
    tick();
    bus.sndstart = 1'b0;
    tick();
  endtask

  task automatic read_cmd();
    bus.cmd_rd = 1'b1;
    tick();
    bus.cmd_rd = 1'b0;
    tick();
  endtask

  task automatic ack_nmi();
    bus.cpu_nmia = 1'b1;
    tick();
    bus.cpu_nmia = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.sndno    = 8'h00;
    bus.sndstart = 1'b0;
    bus.cmd_rd   = 1'b0;
    bus.cpu_irqa = 1'b0;
    bus.cpu_nmia = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int         rises[$];
    logic       prev_irq;
    int         guard;

    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk40M);
    #1;
    chk("rst_irq",      32'(bus.cpu_irq),  32'h0);
    chk("rst_nmi",      32'(bus.cpu_nmi),  32'h0);
    chk("rst_comlatch", 32'(bus.comlatch), 32'h00);
    chk("rst_status",   32'(bus.status),   32'h40);
    reset = 1'b0;
    repeat (2) tick();

    // Single command
    push_byte(8'h23);
    chk("single_latch", 32'(bus.comlatch), 32'h23);
    chk("single_nmi",   32'(bus.cpu_nmi),  32'h1);
    ack_nmi();
    read_cmd();
    repeat (3) tick();
    chk("single_empty",  32'(bus.status),  32'h40);
    chk("single_no_nmi", 32'(bus.cpu_nmi), 32'h0);

    // Burst of three without reads
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    chk("burst_status", 32'(bus.status),   32'h03);
    chk("burst_nmi",    32'(bus.cpu_nmi),  32'h1);
    chk("burst_head",   32'(bus.comlatch), 32'h11);
    ack_nmi();
    read_cmd();
    tick();
    chk("burst_nmi2",   32'(bus.cpu_nmi),  32'h1);
    chk("burst_latch2", 32'(bus.comlatch), 32'h22);
    ack_nmi();
    read_cmd();
    tick();
    chk("burst_nmi3",   32'(bus.cpu_nmi),  32'h1);
    chk("burst_latch3", 32'(bus.comlatch), 32'h33);
    ack_nmi();
    read_cmd();
    tick();
    chk("burst_empty",  32'(bus.status),   32'h40);
    chk("burst_nmi_off", 32'(bus.cpu_nmi), 32'h0);

    // Overflow: fifth byte is dropped
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    push_byte(8'hA5);
    chk("ovf_status", 32'(bus.status),   32'hA4);
    chk("ovf_head",   32'(bus.comlatch), 32'hA1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_status", 32'(bus.status), 32'h24);

    // Simultaneous pop and push while full
    bus.cmd_rd = 1'b1;
    tick();
    bus.cmd_rd   = 1'b0;
    bus.sndno    = 8'hB5;
    bus.sndstart = 1'b1;
    tick();
    bus.sndstart = 1'b0;
    chk("pp_status", 32'(bus.status), 32'h24);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    while (exp_q.size() > 0) begin
      chk("pp_order", 32'(bus.comlatch), 32'(exp_q.pop_front()));
      read_cmd();
    end
    chk("pp_empty", 32'(bus.status), 32'h40);

    // Timer: rise spacing with prompt acks
    prev_irq = bus.cpu_irq;
    for (int i = 0; i < 35; i++) begin
      bus.cpu_irqa = bus.cpu_irq;
      tick();
      if (bus.cpu_irq && !prev_irq) rises.push_back(n_tick);
      prev_irq = bus.cpu_irq;
    end
    bus.cpu_irqa = 1'b0;
    chk("timer_rises", 32'(rises.size() >= 3), 32'h1);
    for (int i = 1; i < rises.size(); i++)
      chk("timer_period", 32'(rises[i] - rises[i-1]), 32'(TICKS));

    // Ack on the terminal-count cycle loses to the set
    guard = 0;
    while (m_tmr != TICKS - 1 && guard < 2 * TICKS) begin
      tick();
      guard++;
    end
    bus.cpu_irqa = 1'b1;
    tick();
    bus.cpu_irqa = 1'b0;
    chk("timer_tc_ack", 32'(bus.cpu_irq), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.sndno    = 8'($urandom);
      bus.sndstart = ($urandom_range(0, 2) == 0);
      bus.cmd_rd   = 1'($urandom_range(0, 1));
      bus.cpu_nmia = ($urandom_range(0, 3) == 0);
      bus.cpu_irqa = ($urandom_range(0, 3) == 0);
      bus.ovf_clr  = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    // Mid-operation reset with pending NMI and IRQ
    push_byte(8'h5A);
    push_byte(8'h6B);
    guard = 0;
    while (!m_irq && guard < 2 * TICKS) begin
      tick();
      guard++;
    end
    chk("pre_rst_nmi", 32'(bus.cpu_nmi), 32'h1);
    chk("pre_rst_irq", 32'(bus.cpu_irq), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_irq",      32'(bus.cpu_irq),  32'h0);
    chk("mid_rst_nmi",      32'(bus.cpu_nmi),  32'h0);
    chk("mid_rst_comlatch", 32'(bus.comlatch), 32'h00);
    chk("mid_rst_status",   32'(bus.status),   32'h40);
    repeat (3) @(posedge clk40M);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    push_byte(8'h77);
    chk("post_rst_latch", 32'(bus.comlatch), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
